// File: rtl/stu_lane_strm_merge_if.sv
// Bundle of the two PE-to-STU lane streams, the merged upstream channel and the merge status.
// The slave modport is the merger's side. The master modport is the lane sources and stu sink.
interface stu_lane_strm_merge_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNTL_W    = 2,
    parameter int unsigned PKT_CNT_W = 16
);
    logic              pe__stu__lane_strm0_data_valid;
    logic [CNTL_W-1:0] pe__stu__lane_strm0_cntl;
    logic [DATA_W-1:0] pe__stu__lane_strm0_data;
    logic [DATA_W-1:0] pe__stu__lane_strm0_data_mask;
    logic              stu__pe__lane_strm0_ready;

    logic              pe__stu__lane_strm1_data_valid;
    logic [CNTL_W-1:0] pe__stu__lane_strm1_cntl;
    logic [DATA_W-1:0] pe__stu__lane_strm1_data;
    logic [DATA_W-1:0] pe__stu__lane_strm1_data_mask;
    logic              stu__pe__lane_strm1_ready;

    logic              mrg__stu__valid;
    logic [CNTL_W-1:0] mrg__stu__cntl;
    logic [DATA_W-1:0] mrg__stu__data;
    logic [DATA_W-1:0] mrg__stu__data_mask;
    logic              mrg__stu__strm_id;
    logic              stu__mrg__ready;

    logic [PKT_CNT_W-1:0] mrg__sys__pkt_cnt0;
    logic [PKT_CNT_W-1:0] mrg__sys__pkt_cnt1;
    logic [1:0]           mrg__sys__proto_err;

    modport slave (
        input  pe__stu__lane_strm0_data_valid, pe__stu__lane_strm0_cntl,
               pe__stu__lane_strm0_data, pe__stu__lane_strm0_data_mask,
        input  pe__stu__lane_strm1_data_valid, pe__stu__lane_strm1_cntl,
               pe__stu__lane_strm1_data, pe__stu__lane_strm1_data_mask,
        input  stu__mrg__ready,
        output stu__pe__lane_strm0_ready, stu__pe__lane_strm1_ready,
        output mrg__stu__valid, mrg__stu__cntl, mrg__stu__data, mrg__stu__data_mask,
        output mrg__stu__strm_id,
        output mrg__sys__pkt_cnt0, mrg__sys__pkt_cnt1, mrg__sys__proto_err
    );

    modport master (
        output pe__stu__lane_strm0_data_valid, pe__stu__lane_strm0_cntl,
               pe__stu__lane_strm0_data, pe__stu__lane_strm0_data_mask,
        output pe__stu__lane_strm1_data_valid, pe__stu__lane_strm1_cntl,
               pe__stu__lane_strm1_data, pe__stu__lane_strm1_data_mask,
        output stu__mrg__ready,
        input  stu__pe__lane_strm0_ready, stu__pe__lane_strm1_ready,
        input  mrg__stu__valid, mrg__stu__cntl, mrg__stu__data, mrg__stu__data_mask,
        input  mrg__stu__strm_id,
        input  mrg__sys__pkt_cnt0, mrg__sys__pkt_cnt1, mrg__sys__proto_err
    );
endinterface

// File: rtl/stu_lane_strm_merge.sv
// Buffers the two PE-to-STU lane streams in per-stream FIFOs and merges them
// packet-atomically, with round-robin arbitration, onto one upstream channel.
module stu_lane_strm_merge #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNTL_W     = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PKT_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    stu_lane_strm_merge_if.slave  bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [CNTL_W-1:0] C_MOM     = CNTL_W'(0);
    localparam logic [CNTL_W-1:0] C_SOM     = CNTL_W'(1);
    localparam logic [CNTL_W-1:0] C_EOM     = CNTL_W'(2);
    localparam logic [CNTL_W-1:0] C_SOM_EOM = CNTL_W'(3);

    typedef struct packed {
        logic [CNTL_W-1:0] cntl;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
    } beat_t;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    beat_t                mem [2][FIFO_DEPTH];
    beat_t                in_beat [2];
    beat_t                head [2];
    logic [AW-1:0]        wr_ptr [2];
    logic [AW-1:0]        rd_ptr [2];
    logic [CW-1:0]        cnt [2];
    logic [CW-1:0]        cnt_nxt [2];
    logic [PKT_CNT_W-1:0] pkt_cnt_q [2];
    logic [1:0]           in_valid, push, pop, empty, ready_q, open_q, err_q;

    state_t state_q, state_nxt;
    logic   last_q;
    logic   cur, out_valid, eom_pop;

    always_comb begin
        in_beat[0] = '{cntl: bus.pe__stu__lane_strm0_cntl, data: bus.pe__stu__lane_strm0_data,
                       mask: bus.pe__stu__lane_strm0_data_mask};
        in_beat[1] = '{cntl: bus.pe__stu__lane_strm1_cntl, data: bus.pe__stu__lane_strm1_data,
                       mask: bus.pe__stu__lane_strm1_data_mask};
    end

    assign in_valid = {bus.pe__stu__lane_strm1_data_valid, bus.pe__stu__lane_strm0_data_valid};
    assign push     = in_valid & ready_q;

    // FIFO head, emptiness and next occupancy
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            head[i]    = mem[i][rd_ptr[i]];
            empty[i]   = (cnt[i] == '0);
            cnt_nxt[i] = cnt[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // Arbiter: the grant only moves after a packet-ending beat has been popped
    always_comb begin
        state_nxt = state_q;
        pop       = '0;
        cur       = (state_q == GNT1);
        out_valid = 1'b0;
        eom_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty[0] && !empty[1]) state_nxt = last_q ? GNT0 : GNT1;
                else if (!empty[0])         state_nxt = GNT0;
                else if (!empty[1])         state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                out_valid = !empty[cur];
                pop[cur]  = out_valid && bus.stu__mrg__ready;
                eom_pop   = pop[cur] && (head[cur].cntl == C_EOM || head[cur].cntl == C_SOM_EOM);
                if (eom_pop) begin
                    if (!empty[~cur])           state_nxt = cur ? GNT0 : GNT1;
                    else if (cnt[cur] > CW'(1)) state_nxt = state_q;
                    else                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_beat[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_poweron) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            ready_q <= '0;
            open_q  <= '0;
            err_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i]    <= '0;
                rd_ptr[i]    <= '0;
                cnt[i]       <= '0;
                pkt_cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_nxt;
            for (int i = 0; i < 2; i++) begin
                cnt[i]     <= cnt_nxt[i];
                ready_q[i] <= (cnt_nxt[i] <= CW'(FIFO_DEPTH - 2));
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                // SOM/EOM framing check on every accepted beat
                if (push[i]) begin
                    case (in_beat[i].cntl)
                        C_SOM: begin
                            if (open_q[i]) err_q[i] <= 1'b1;
                            open_q[i] <= 1'b1;
                        end
                        C_SOM_EOM: begin
                            if (open_q[i]) err_q[i] <= 1'b1;
                            open_q[i] <= 1'b0;
                        end
                        C_EOM: begin
                            if (!open_q[i]) err_q[i] <= 1'b1;
                            open_q[i] <= 1'b0;
                        end
                        C_MOM: begin
                            if (!open_q[i]) err_q[i] <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            if (eom_pop) begin
                last_q         <= cur;
                pkt_cnt_q[cur] <= pkt_cnt_q[cur] + PKT_CNT_W'(1);
            end
        end
    end

    assign bus.stu__pe__lane_strm0_ready = ready_q[0];
    assign bus.stu__pe__lane_strm1_ready = ready_q[1];
    assign bus.mrg__stu__valid           = out_valid;
    assign bus.mrg__stu__cntl            = head[cur].cntl;
    assign bus.mrg__stu__data            = head[cur].data;
    assign bus.mrg__stu__data_mask       = head[cur].mask;
    assign bus.mrg__stu__strm_id         = cur;
    assign bus.mrg__sys__pkt_cnt0        = pkt_cnt_q[0];
    assign bus.mrg__sys__pkt_cnt1        = pkt_cnt_q[1];
    assign bus.mrg__sys__proto_err       = err_q;
endmodule
